data_fill_writer: RTL
=====================

# data_fill_writer

Write-side sequencer for the four quarter-line data blockrams of the cache. Accepts line fills from the memory side as four 128-bit beats, plus single-quarter store writes from the pipeline, and drives one shared registered write bus (address, data, per-quarter write enables) into the four blockrams. Sits between the miss handler and store path on one side and the blockram write ports on the other. The read port of the blockrams is untouched.

## Interface
- INDEX_W, 10, set index width
- WAY_W, 2, way select width; blockram write address is {index, way}
- BEAT_W, 128, quarter-line width; four beats per 512-bit line

Ports:
- clk  in  1  single clock; also drives blockram write port
- rst  in  1  asynchronous, active-high reset
- fill_req_valid  in  1  fill request offered
- fill_req_ready  out  1  fill request accepted when both high
- fill_index  in  10  set of line being filled
- fill_way  in  2  way receiving the line
- fill_crit  in  2  quarter delivered by the first beat (critical-word-first)
- beat_valid  in  1  fill data beat offered
- beat_ready  out  1  beat accepted when both high
- beat_data  in  128  fill data beat
- store_valid  in  1  store write offered
- store_ready  out  1  store accepted when both high
- store_index  in  10  store set
- store_way  in  2  store way
- store_quarter  in  2  quarter of line written by store
- store_data  in  128  store data
- bram_wr_en  out  4  one-hot write enable, bit q = quarter-q blockram
- bram_wr_addr  out  12  {index, way}
- bram_wr_data  out  128  write data
- fill_done  out  1  one-cycle pulse with the last fill write
- busy  out  1  high while in FILL

## Operation
- States: IDLE, FILL.
- IDLE: store_ready = 1; fill_req_ready = !store_valid (store wins a same-cycle conflict); beat_ready = 0.
- Store accept in IDLE: next cycle bram_wr_en = 1 << store_quarter, addr = {store_index, store_way}, data = store_data. State stays IDLE.
- Fill accept: latch index, way, quarter pointer q = fill_crit, beat count = 0; go to FILL.
- FILL: beat_ready = 1, store_ready = 0, fill_req_ready = 0. Each accepted beat: next cycle bram_wr_en = 1 << q, addr = latched {index, way}, data = beat_data; q increments mod 4 (wraps 3→0); count increments.
- Fourth accepted beat: state → IDLE; fill_done pulses in the same cycle that write appears on the bus.
- Beat stalls (beat_valid low) hold state and count; bram_wr_en = 0 on that next cycle.
- beat_valid in IDLE is ignored, no write.
- Every quarter is written exactly once per fill; no quarter written twice.

## Timing
- Reset values: bram_wr_en = 0, bram_wr_addr = 0, bram_wr_data = 0, fill_done = 0, busy = 0; state IDLE, count 0, q 0.
- All bram_* outputs, fill_done, busy are registered; ready outputs are combinational from state and store_valid.
- Latency: handshake in cycle N → write on bus in cycle N+1; bram_wr_en deasserts in any cycle with no handshake in the prior cycle.
- Minimum fill: request cycle + 4 beat cycles; writes in cycles 2..5 after request; fill_done in cycle 5.
- Back-to-back: a new fill or store may be accepted in the cycle the last fill write is on the bus (state already IDLE).
- Reset mid-fill: return to IDLE immediately, bram_wr_en = 0; partially written line is not repaired; miss handler must reissue the fill.

## Test plan
- Reset → all outputs 0, fill_req_ready = 1, store_ready = 1, beat_ready = 0.
- Store index 0x155, way 2, quarter 3, data 0xA5…A5 → next cycle bram_wr_en = 4'b1000, bram_wr_addr = 0x556, data matches; one cycle only.
- Fill index 0x3FF, way 1, crit 2, four back-to-back beats D0..D3 → enables 0100, 1000, 0001, 0010 on consecutive cycles, addr 0xFFD each, data D0..D3, fill_done with the 0010 write, busy low after.
- Fill with beat_valid gaps (beats on cycles 1, 4, 5, 9) → writes exactly at cycles 2, 5, 6, 10; bram_wr_en = 0 in between; store_valid during fill sees store_ready = 0.
- store_valid and fill_req_valid together in IDLE → store written next cycle, fill_req_ready = 0 that cycle; fill accepted the following cycle.
- rst asserted after second beat → bram_wr_en = 0 immediately, busy = 0, next fill with crit 0 starts at quarter 0 with fresh count.

Source files
------------

// File: rtl/data_fill_writer.sv
// data_fill_writer: write-side sequencer for the four quarter-line data
// blockrams. Merges 4-beat line fills (critical quarter first) and
// single-quarter store writes onto one registered write bus.
module data_fill_writer #(
  parameter int INDEX_W = 10,
  parameter int WAY_W   = 2,
  parameter int BEAT_W  = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fill_req_valid,
  output logic                       fill_req_ready,
  input  logic [INDEX_W-1:0]         fill_index,
  input  logic [WAY_W-1:0]           fill_way,
  input  logic [1:0]                 fill_crit,
  input  logic                       beat_valid,
  output logic                       beat_ready,
  input  logic [BEAT_W-1:0]          beat_data,
  input  logic                       store_valid,
  output logic                       store_ready,
  input  logic [INDEX_W-1:0]         store_index,
  input  logic [WAY_W-1:0]           store_way,
  input  logic [1:0]                 store_quarter,
  input  logic [BEAT_W-1:0]          store_data,
  output logic [3:0]                 bram_wr_en,
  output logic [INDEX_W+WAY_W-1:0]   bram_wr_addr,
  output logic [BEAT_W-1:0]          bram_wr_data,
  output logic                       fill_done,
  output logic                       busy
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                     state_q, state_d;
  logic [INDEX_W-1:0]         idx_q, idx_d;
  logic [WAY_W-1:0]           way_q, way_d;
  logic [1:0]                 qptr_q, qptr_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [3:0]                 wr_en_q, wr_en_d;
  logic [INDEX_W+WAY_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BEAT_W-1:0]          wr_data_q, wr_data_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;

  // Handshake readies: store wins over a same-cycle fill request in IDLE.
  always_comb begin
    store_ready    = (state_q == IDLE);
    fill_req_ready = (state_q == IDLE) && !store_valid;
    beat_ready     = (state_q == FILL);
  end

  // Next-state: accept store/fill in IDLE, sequence quarters during FILL.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    way_d     = way_q;
    qptr_d    = qptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 4'b0000;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (store_valid) begin
          wr_en_d   = 4'b0001 << store_quarter;
          wr_addr_d = {store_index, store_way};
          wr_data_d = store_data;
        end else if (fill_req_valid) begin
          idx_d   = fill_index;
          way_d   = fill_way;
          qptr_d  = fill_crit;
          cnt_d   = 2'd0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (beat_valid) begin
          wr_en_d   = 4'b0001 << qptr_q;
          wr_addr_d = {idx_q, way_q};
          wr_data_d = beat_data;
          qptr_d    = qptr_q + 2'd1;   // wraps 3 -> 0
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FILL);
  end

  // State and registered write bus; reset abandons any partial fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      way_q     <= '0;
      qptr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      way_q     <= way_d;
      qptr_q    <= qptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;
  assign fill_done    = done_q;
  assign busy         = busy_q;

endmodule
